// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared types and helpers for the Keccak squeeze serializer
package keccak_pkg;

    localparam int SER_LEN_WIDTH = 16;
    localparam int SER_KEEP_MAX  = 64;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_LOAD,
        SER_EMIT,
        SER_DRAIN
    } ser_state_t;

    // Contiguous byte-enable mask with the low n bits set.
    function automatic logic [SER_KEEP_MAX-1:0] keep_from_bytes(input int unsigned n);
        logic [SER_KEEP_MAX-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < SER_KEEP_MAX; i++) begin
            k[i] = (i < n);
        end
        return k;
    endfunction

endpackage

// File: rtl/keccak_squeeze_serializer.sv
// rtl/keccak_squeeze_serializer.sv - wide squeeze words to narrow beats, truncated to the requested length
module keccak_squeeze_serializer
    import keccak_pkg::*;
#(
    parameter int IN_WIDTH  = 256,
    parameter int OUT_WIDTH = 64,
    parameter int LEN_WIDTH = SER_LEN_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [LEN_WIDTH-1:0]   out_len_i,
    input  logic [IN_WIDTH-1:0]    s_data_i,
    input  logic                   s_valid_i,
    input  logic                   s_last_i,
    output logic                   s_ready_o,
    output logic [OUT_WIDTH-1:0]   m_data_o,
    output logic [OUT_WIDTH/8-1:0] m_keep_o,
    output logic                   m_valid_o,
    output logic                   m_last_o,
    input  logic                   m_ready_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   len_err_o
);

    localparam int NCHUNK = IN_WIDTH / OUT_WIDTH;
    localparam int KEEP_W = OUT_WIDTH / 8;
    localparam int CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [LEN_WIDTH-1:0] BPB = LEN_WIDTH'(KEEP_W);

    ser_state_t            state_q;
    logic [IN_WIDTH-1:0]   buf_q;
    logic                  word_last_q;
    logic [CIDX_W-1:0]     chunk_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic                  len_err_q;
    logic                  done_q;

    logic [OUT_WIDTH-1:0]  chunks [NCHUNK];
    logic [LEN_WIDTH-1:0]  nbytes;
    logic                  last_chunk;
    logic                  beat_last;
    logic                  emit;

    always_comb begin
        for (int i = 0; i < NCHUNK; i++) begin
            chunks[i] = buf_q[i*OUT_WIDTH +: OUT_WIDTH];
        end
    end

    assign emit       = (state_q == SER_EMIT);
    assign nbytes     = (rem_q < BPB) ? rem_q : BPB;
    assign last_chunk = (chunk_q == CIDX_W'(NCHUNK - 1));
    assign beat_last  = (rem_q <= BPB) || (last_chunk && word_last_q);

    // Beat outputs are decoded from registers only, so they hold across a stall.
    assign m_valid_o = emit;
    assign m_data_o  = emit ? chunks[chunk_q] : '0;
    assign m_keep_o  = emit ? KEEP_W'(keep_from_bytes(32'(nbytes))) : '0;
    assign m_last_o  = emit && beat_last;
    assign s_ready_o = (state_q == SER_LOAD) || (state_q == SER_DRAIN);
    assign busy_o    = (state_q != SER_IDLE);
    assign done_o    = done_q;
    assign len_err_o = len_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SER_IDLE;
            buf_q       <= '0;
            word_last_q <= 1'b0;
            chunk_q     <= '0;
            rem_q       <= '0;
            len_err_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                SER_IDLE: begin
                    if (start_i) begin
                        rem_q     <= out_len_i;
                        len_err_q <= 1'b0;
                        state_q   <= (out_len_i == '0) ? SER_DRAIN : SER_LOAD;
                    end
                end
                SER_LOAD: begin
                    if (s_valid_i) begin
                        buf_q       <= s_data_i;
                        word_last_q <= s_last_i;
                        chunk_q     <= '0;
                        state_q     <= SER_EMIT;
                    end
                end
                SER_EMIT: begin
                    if (m_ready_i) begin
                        rem_q   <= rem_q - nbytes;
                        chunk_q <= chunk_q + CIDX_W'(1);
                        if (beat_last) begin
                            // Ending with bytes still owed means the core ran out of words.
                            if (rem_q > nbytes) begin
                                len_err_q <= 1'b1;
                            end
                            if (word_last_q) begin
                                state_q <= SER_IDLE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= SER_DRAIN;
                            end
                        end else if (last_chunk) begin
                            state_q <= SER_LOAD;
                        end
                    end
                end
                SER_DRAIN: begin
                    if (s_valid_i && s_last_i) begin
                        state_q <= SER_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= SER_IDLE;
            endcase
        end
    end

endmodule
